fmul_sp: RTL and testbench

- IEEE-754 single-precision floating-point multiplier for the FPU datapath.
- Computes y = x1 * x2 with a one-cycle registered output.
- Targets a simplified FPU: subnormals flush to zero, results are correct within ±1 ulp of the IEEE round-to-nearest result, and there is no NaN handling.

---
 rtl/fpu_pkg.sv | 15 +
 rtl/fmul_mant_mul.sv | 11 +
 rtl/fmul_sp.sv | 75 +++++++
 tb/tb_fmul_sp.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: single-precision field widths and the packed word layout.
package fpu_pkg;

  localparam int          EXP_W   = 8;
  localparam int          FRAC_W  = 23;
  localparam int          BIAS    = 127;
  localparam logic [7:0]  EXP_MAX = 8'hFF;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/fmul_mant_mul.sv
// Combinational 24x24 unsigned mantissa multiplier; isolated so a DSP-mapped or
// Booth implementation can drop in behind the same ports.
module fmul_mant_mul (
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic [47:0] p
);

  assign p = a * b;

endmodule

// File: rtl/fmul_sp.sv
// Single-precision multiplier: flush-to-zero inputs, round-half-up on the guard
// bit, saturation to signed infinity, one registered output stage.
module fmul_sp
  import fpu_pkg::*;
(
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y,
  input  logic        clk,
  input  logic        rst
);

  fp32_t a, b, r;
  logic  [47:0] prod;
  logic  [25:0] prod_hi;
  logic  [21:0] prod_unused;

  logic               s;
  logic               zero_in;
  logic signed [9:0]  e_sum, e_norm, e_fin;
  logic [FRAC_W-1:0]  frac_n, frac_r;
  logic               guard, carry;

  assign a = fp32_t'(x1);
  assign b = fp32_t'(x2);

  fmul_mant_mul u_mant_mul (
    .a ({1'b1, a.frac}),
    .b ({1'b1, b.frac}),
    .p (prod)
  );

  // Only bits 47:22 can reach the fraction or guard; the rest would feed a sticky bit.
  assign prod_hi     = prod[47:22];
  assign prod_unused = prod[21:0];

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    s       = a.sign ^ b.sign;
    zero_in = (a.exp == '0) || (b.exp == '0);
    e_sum   = signed'({2'b00, a.exp}) + signed'({2'b00, b.exp}) - signed'(10'(BIAS));
    e_norm  = e_sum;
    frac_n  = prod_hi[23:1];
    guard   = prod_hi[0];

    if (prod_hi[25]) begin
      frac_n = prod_hi[24:2];
      guard  = prod_hi[1];
      e_norm = e_sum + 10'sd1;
    end

    // A carry out leaves frac_r at zero, which is exactly the renormalised fraction.
    {carry, frac_r} = {1'b0, frac_n} + {{FRAC_W{1'b0}}, guard};
    e_fin           = carry ? e_norm + 10'sd1 : e_norm;

    r.sign = s;
    r.exp  = e_fin[EXP_W-1:0];
    r.frac = frac_r;
    if (zero_in || e_fin <= 10'sd0) begin
      r.exp  = '0;
      r.frac = '0;
    end else if (e_fin >= signed'({2'b00, EXP_MAX})) begin
      r.exp  = EXP_MAX;
      r.frac = '0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) y <= '0;
    else     y <= r;
  end

endmodule

// File: tb/tb_fmul_sp.sv
// Scoreboard bench for fmul_sp: directed cases from the plan plus a random sweep
// checked against an exact round-to-nearest-even reference model.
module tb_fmul_sp;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] x1, x2, y;

  fmul_sp dut (
    .x1  (x1),
    .x2  (x2),
    .y   (y),
    .clk (clk),
    .rst (rst)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    int          tol;
  } sb_t;

  sb_t         sb[$];
  sb_t         mon_item;
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          mon_en   = 1'b0;
  logic [22:0] edges [7] = '{23'h000000, 23'h000001, 23'h000002, 23'h380000,
                             23'h400000, 23'h5FFFFF, 23'h7FFFFF};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp, input int tol);
    logic [31:0] d;
    n_checks++;
    d = (got >= exp) ? got - exp : exp - got;
    if (d > 32'(tol)) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Exact IEEE product with round-to-nearest-even, flush-to-zero and saturation.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s, g, st;
    logic [47:0] p;
    logic [22:0] f;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'b0};
    p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      f = p[46:24]; g = p[23]; st = |p[22:0]; e++;
    end else begin
      f = p[45:23]; g = p[22]; st = |p[21:0];
    end
    if (g && (st || f[0])) begin
      if (&f) begin f = '0; e++; end
      else        f = f + 23'd1;
    end
    if (e <= 0)   return {s, 31'b0};
    if (e >= 255) return {s, 8'hFF, 23'b0};
    return {s, e[7:0], f};
  endfunction

  task automatic drive(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int tol);
    sb_t it;
    @(negedge clk);
    x1 = a;
    x2 = b;
    it.tag = tag;
    it.exp = exp;
    it.tol = tol;
    sb.push_back(it);
  endtask

  function automatic logic [22:0] pick_mant();
    int idx;
    idx = $urandom_range(0, 9);
    if (idx < 7) return edges[idx];
    return 23'($urandom);
  endfunction

  // Inputs applied at a negedge are captured at the next posedge; y is read just after.
  always @(posedge clk) begin
    #2;
    if (mon_en && sb.size() > 0) begin
      mon_item = sb.pop_front();
      check(mon_item.tag, y, mon_item.exp, mon_item.tol);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, b, e;
    rst = 1'b1;
    x1  = '0;
    x2  = '0;
    #1 check("reset_y", y, 32'h0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    mon_en = 1'b1;

    drive("one",       32'h3F800000, 32'h3F800000, 32'h3F800000, 0);
    drive("1p5_sq",    32'h3FC00000, 32'h3FC00000, 32'h40100000, 0);
    drive("pos_neg",   32'h40000000, 32'hC0400000, 32'hC0C00000, 0);
    drive("neg_neg",   32'hC0000000, 32'hC0400000, 32'h40C00000, 0);
    drive("zero",      32'h00000000, 32'h40A00000, 32'h00000000, 0);
    drive("neg_zero",  32'h80000000, 32'h3F800000, 32'h80000000, 0);
    drive("subnorm",   32'h00400000, 32'h3F800000, 32'h00000000, 0);
    drive("underflow", 32'h00800000, 32'h00800000, 32'h00000000, 0);
    drive("overflow",  32'h7F000000, 32'h7F000000, 32'h7F800000, 0);
    drive("neg_ovf",   32'hFF000000, 32'h7F000000, 32'hFF800000, 0);
    drive("round",     32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 1);

    for (int i = 0; i < 300; i++) begin
      a = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 253)), pick_mant()};
      b = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 253)), pick_mant()};
      e = ref_mul(a, b);
      drive("rand", a, b, e, (e[30:23] != 8'h00 && e[30:23] != 8'hFF) ? 1 : 0);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #3 check("drain_empty", 32'(sb.size()), 32'h0, 0);
    mon_en = 1'b0;

    @(negedge clk);
    x1 = 32'h40000000;
    x2 = 32'hC0400000;
    @(posedge clk);
    #2 check("pre_rst", y, 32'hC0C00000, 0);
    #1 rst = 1'b1;
    #1 check("rst_async", y, 32'h0, 0);
    @(posedge clk);
    #2 check("rst_hold", y, 32'h0, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #2 check("post_rst", y, 32'hC0C00000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
